// File: rtl/store_drain_fifo.sv
// Committed-store buffer: queues datafifo_* stores and drains them in order to the
// memory write port with lane-aligned strobes. Define STORE_DRAIN_FIFO_HAZARD_EN for the load-hazard check.
module store_drain_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] datafifo_addr_in,
  input  logic [31:0] datafifo_val_in,
  input  logic [1:0]  datafifo_size_in,
  input  logic        datafifo_valid_in,
  output logic        datafifo_full,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_strb,
  output logic        mem_wr_valid,
  input  logic        mem_wr_ready,
  output logic        fifo_empty,
  output logic        overflow,
  input  logic [31:0] chk_addr,
  output logic        chk_hit
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      val_q  [DEPTH];
  logic [1:0]       size_q [DEPTH];
  logic [PTR_W-1:0] wp, rp;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             full_q, empty_q;
  logic             push, pop;

  // Byte-lane enables for one entry; misaligned or reserved sizes give no lanes.
  function automatic logic [3:0] lane_strb(input logic [1:0] off, input logic [1:0] size);
    logic [3:0] s;
    s = 4'b0000;
    case (size)
      2'd0: s = 4'(4'b0001 << off);
      2'd1: if (!off[0]) s = 4'(4'b0011 << off);
      2'd2: if (off == 2'd0) s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  assign push = datafifo_valid_in && !full_q;
  assign pop  = !empty_q && mem_wr_ready;

  always_comb begin
    cnt_next = cnt;
    case ({push, pop})
      2'b10:   cnt_next = cnt + CNT_W'(1);
      2'b01:   cnt_next = cnt - CNT_W'(1);
      default: cnt_next = cnt;
    endcase
  end

  // Pointers, occupancy and flags; flags are registered from the next count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + PTR_W'(1);
      if (pop)  rp <= rp + PTR_W'(1);
      cnt     <= cnt_next;
      full_q  <= (cnt_next == CNT_W'(DEPTH));
      empty_q <= (cnt_next == '0);
      if (datafifo_valid_in && full_q) overflow <= 1'b1;
    end
  end

  // Entry storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wp] <= datafifo_addr_in;
      val_q[wp]  <= datafifo_val_in;
      size_q[wp] <= datafifo_size_in;
    end
  end

  assign datafifo_full = full_q;
  assign fifo_empty    = empty_q;
  assign mem_wr_valid  = !empty_q;

  // Head formatting onto the write port; zeros while empty.
  always_comb begin
    mem_wr_addr = 32'h0;
    mem_wr_data = 32'h0;
    mem_wr_strb = 4'h0;
    if (!empty_q) begin
      mem_wr_addr = {addr_q[rp][31:2], 2'b00};
      mem_wr_strb = lane_strb(addr_q[rp][1:0], size_q[rp]);
      case (size_q[rp])
        2'd0:    mem_wr_data = {4{val_q[rp][7:0]}};
        2'd1:    mem_wr_data = {2{val_q[rp][15:0]}};
        default: mem_wr_data = val_q[rp];
      endcase
    end
  end

`ifdef STORE_DRAIN_FIFO_HAZARD_EN
  logic [PTR_W-1:0] idx;

  // Any pending entry with live lanes in chk_addr's word raises a hit.
  always_comb begin
    chk_hit = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rp + PTR_W'(i);
      if ((CNT_W'(i) < cnt) && (addr_q[idx][31:2] == chk_addr[31:2]) &&
          (lane_strb(addr_q[idx][1:0], size_q[idx]) != 4'b0000))
        chk_hit = 1'b1;
    end
  end
`else
  logic unused_chk;
  assign unused_chk = ^chk_addr;
  assign chk_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_store_drain_fifo.sv
// Randomized and directed bench for store_drain_fifo against a queue-based reference model.
module tb_store_drain_fifo;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] datafifo_addr_in = '0;
  logic [31:0] datafifo_val_in = '0;
  logic [1:0]  datafifo_size_in = '0;
  logic        datafifo_valid_in = 1'b0;
  logic        datafifo_full;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic        mem_wr_valid;
  logic        mem_wr_ready = 1'b0;
  logic        fifo_empty;
  logic        overflow;
  logic [31:0] chk_addr = '0;
  logic        chk_hit;

  int checks = 0;
  int failures = 0;

  store_drain_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .datafifo_addr_in(datafifo_addr_in), .datafifo_val_in(datafifo_val_in),
    .datafifo_size_in(datafifo_size_in), .datafifo_valid_in(datafifo_valid_in),
    .datafifo_full(datafifo_full),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .fifo_empty(fifo_empty), .overflow(overflow),
    .chk_addr(chk_addr), .chk_hit(chk_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] v;
    logic [1:0]  s;
  } ent_t;

  ent_t q[$];
  logic ovf_m = 1'b0;

  logic [72:0] dut_vec;
  assign dut_vec = {fifo_empty, datafifo_full, mem_wr_valid, mem_wr_addr,
                    mem_wr_data, mem_wr_strb, overflow, chk_hit};

  function automatic logic [3:0] m_strb(input logic [31:0] a, input logic [1:0] s);
    logic [1:0] o;
    o = a[1:0];
    if (s == 2'd0) begin
      if (o == 2'd0) return 4'b0001;
      if (o == 2'd1) return 4'b0010;
      if (o == 2'd2) return 4'b0100;
      return 4'b1000;
    end
    if (s == 2'd1) begin
      if (o == 2'd0) return 4'b0011;
      if (o == 2'd2) return 4'b1100;
      return 4'b0000;
    end
    if (s == 2'd2 && o == 2'd0) return 4'b1111;
    return 4'b0000;
  endfunction

  function automatic logic [31:0] m_data(input logic [31:0] v, input logic [1:0] s);
    if (s == 2'd0) return {v[7:0], v[7:0], v[7:0], v[7:0]};
    if (s == 2'd1) return {v[15:0], v[15:0]};
    return v;
  endfunction

  function automatic logic m_hit();
    logic h;
    h = 1'b0;
`ifdef STORE_DRAIN_FIFO_HAZARD_EN
    foreach (q[i])
      if (q[i].a[31:2] == chk_addr[31:2] && m_strb(q[i].a, q[i].s) != 4'b0) h = 1'b1;
`endif
    return h;
  endfunction

  function automatic logic [72:0] exp_vec();
    logic [31:0] a, d;
    logic [3:0]  st;
    a = '0; d = '0; st = '0;
    if (q.size() != 0) begin
      a  = q[0].a & 32'hFFFF_FFFC;
      d  = m_data(q[0].v, q[0].s);
      st = m_strb(q[0].a, q[0].s);
    end
    return {q.size() == 0, q.size() == DEPTH, q.size() != 0, a, d, st, ovf_m, m_hit()};
  endfunction

  // One clock: drive inputs, advance the model at the edge, settle 1 time unit after.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic r);
    logic was_full, do_pop;
    datafifo_valid_in = v;
    datafifo_addr_in  = a;
    datafifo_val_in   = d;
    datafifo_size_in  = s;
    mem_wr_ready      = r;
    @(posedge clk);
    was_full = (q.size() == DEPTH);
    do_pop   = (q.size() != 0) && r;
    if (v && was_full) ovf_m = 1'b1;
    if (do_pop) void'(q.pop_front());
    if (v && !was_full) q.push_back('{a: a, v: d, s: s});
    #1;
  endtask

  task automatic do_reset();
    datafifo_valid_in = 1'b0;
    mem_wr_ready = 1'b0;
    reset = 1'b0;
    q.delete();
    ovf_m = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== exp_vec() || fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_word_hold();
    do_reset();
    cycle(1'b1, 32'h1000, 32'hDEADBEEF, 2'd2, 1'b0);
    checks++;
    if (dut_vec !== exp_vec() || mem_wr_strb !== 4'hF || mem_wr_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL word_push: got %h want %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, '0, 2'd0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec() || mem_wr_addr !== 32'h1000) begin
        failures++;
        $display("FAIL word_hold%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    cycle(1'b0, '0, '0, 2'd0, 1'b1);
    checks++;
    if (dut_vec !== exp_vec() || fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL word_pop: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 2'd2, 1'b0);
    checks++;
    if (dut_vec !== exp_vec() || datafifo_full !== 1'b1) begin
      failures++;
      $display("FAIL fill_full: got %h want %h", dut_vec, exp_vec());
    end
    cycle(1'b1, 32'h200, 32'hBAD, 2'd2, 1'b0);
    checks++;
    if (dut_vec !== exp_vec() || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set: got %h want %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      cycle(1'b0, '0, '0, 2'd0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL drain%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_full_push_pop();
    int pops;
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'h500 + 32'(4 * i), 32'h5500 + 32'(i), 2'd2, 1'b0);
    cycle(1'b1, 32'h600, 32'hFEED, 2'd2, 1'b1);
    checks++;
    if (dut_vec !== exp_vec() || overflow !== 1'b1 || datafifo_full !== 1'b0) begin
      failures++;
      $display("FAIL full_push_pop: got %h want %h", dut_vec, exp_vec());
    end
    pops = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (mem_wr_valid === 1'b1) pops++;
      checks++;
      if (dut_vec !== exp_vec() || (mem_wr_valid === 1'b1 && mem_wr_data === 32'hFEED)) begin
        failures++;
        $display("FAIL fpp_drain%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      cycle(1'b0, '0, '0, 2'd0, 1'b1);
    end
    checks++;
    if (pops != DEPTH - 1) begin
      failures++;
      $display("FAIL fpp_count: got %0d want %0d", pops, DEPTH - 1);
    end
  endtask

  task automatic test_lanes();
    do_reset();
    cycle(1'b1, 32'h2003, 32'h0000_00AB, 2'd0, 1'b0);
    cycle(1'b1, 32'h2002, 32'h0000_1234, 2'd1, 1'b0);
    cycle(1'b1, 32'h2001, 32'h0000_5678, 2'd1, 1'b0);
    checks++;
    if (dut_vec !== exp_vec() || mem_wr_strb !== 4'b1000 || mem_wr_data !== 32'hABABABAB) begin
      failures++;
      $display("FAIL lane_byte: got %h want %h", dut_vec, exp_vec());
    end
    cycle(1'b0, '0, '0, 2'd0, 1'b1);
    checks++;
    if (dut_vec !== exp_vec() || mem_wr_strb !== 4'b1100 || mem_wr_data !== 32'h12341234) begin
      failures++;
      $display("FAIL lane_half: got %h want %h", dut_vec, exp_vec());
    end
    cycle(1'b0, '0, '0, 2'd0, 1'b1);
    checks++;
    if (dut_vec !== exp_vec() || mem_wr_strb !== 4'b0000 || mem_wr_valid !== 1'b1) begin
      failures++;
      $display("FAIL lane_misaligned: got %h want %h", dut_vec, exp_vec());
    end
    cycle(1'b0, '0, '0, 2'd0, 1'b1);
    checks++;
    if (dut_vec !== exp_vec() || fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL misaligned_pop: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_stream();
    do_reset();
    cycle(1'b1, 32'h700, $urandom, 2'd2, 1'b0);
    cycle(1'b1, 32'h704, $urandom, 2'd2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 32'h800 + 32'(4 * i), $urandom, 2'($urandom_range(0, 3)), 1'b1);
      checks++;
      if (dut_vec !== exp_vec() || q.size() != 2) begin
        failures++;
        $display("FAIL stream%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    // Reset lands between edges with push and pop still asserted.
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (fifo_empty !== 1'b1 || mem_wr_valid !== 1'b0 || datafifo_full !== 1'b0 ||
        mem_wr_strb !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid: got %h want empty", dut_vec);
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      chk_addr = 32'h4000 + 32'($urandom_range(0, 31));
      cycle(($urandom % 3) != 0, 32'h4000 + 32'($urandom_range(0, 31)), $urandom,
            2'($urandom_range(0, 3)), ($urandom % 2) == 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

`ifdef STORE_DRAIN_FIFO_HAZARD_EN
  task automatic test_hazard();
    do_reset();
    chk_addr = 32'h3006;
    cycle(1'b1, 32'h3004, 32'h1111_2222, 2'd2, 1'b0);
    checks++;
    if (chk_hit !== 1'b1 || dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL hazard_hit: got %b want 1", chk_hit);
    end
    chk_addr = 32'h3008;
    #1;
    checks++;
    if (chk_hit !== 1'b0) begin
      failures++;
      $display("FAIL hazard_other_word: got %b want 0", chk_hit);
    end
    chk_addr = 32'h3006;
    cycle(1'b0, '0, '0, 2'd0, 1'b1);
    checks++;
    if (chk_hit !== 1'b0 || dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL hazard_after_pop: got %b want 0", chk_hit);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_word_hold();
    test_full_overflow();
    test_full_push_pop();
    test_lanes();
    test_stream();
`ifdef STORE_DRAIN_FIFO_HAZARD_EN
    test_hazard();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
